// File: rtl/stress_level_ctrl.sv
// -----------------------------------------------------------------------------
// stress_level_ctrl
//
// Integrates stress_inc / stress_dec request pulses from the stress regulator
// into a saturating stress level, then classifies that level into a mood band
// with hysteresis for the downstream mood and output blocks.
//
// Requests may arrive in any cycle. They are remembered in two pending bits
// and applied together on a fixed update tick, every TICK_DIV cycles, so the
// level moves at a controlled pace no matter how bursty the requests are.
//
// Optional build macro:
//   STRESS_DECAY_EN - when defined, a tick with no effective request lowers
//                     the level by 1 (saturating at 0). When undefined, an
//                     idle tick leaves the level unchanged.
//
// Ports:
//   clk            in   system clock, all state updates on its rising edge
//   rst            in   synchronous active-high reset
//   stress_inc     in   increment request pulse
//   stress_dec     in   decrement request pulse
//   hold           in   freeze updates; tick counter and pending bits pause
//                       (new requests are still latched)
//   stress_level   out  [WIDTH-1:0] current stress level
//   mood_state     out  [1:0] 0=CALM 1=TENSE 2=STRESSED 3=PANIC
//   update_strobe  out  1-cycle pulse in the cycle stress_level has changed
//
// Handshake: stress_inc / stress_dec are single-cycle pulses with no ready;
// a request is never lost, it is either applied on the current tick or held
// pending until the next one. Simultaneous inc and dec in one tick window
// cancel each other.
// -----------------------------------------------------------------------------
module stress_level_ctrl #(
   parameter int WIDTH       = 8,
   parameter int TICK_DIV    = 16,
   parameter int STEP        = 4,
   parameter int TH_TENSE    = 64,
   parameter int TH_STRESSED = 128,
   parameter int TH_PANIC    = 224,
   parameter int HYST        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stress_inc,
   input  logic             stress_dec,
   input  logic             hold,
   output logic [WIDTH-1:0] stress_level,
   output logic [1:0]       mood_state,
   output logic             update_strobe
);

   // ---------------------------------------------------------------------------
   // Elaboration-time constants. Level arithmetic is done one bit wider than
   // the level so an increment past full scale can be detected and clamped.
   // ---------------------------------------------------------------------------
   localparam int                CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

   localparam logic [WIDTH:0]    LVL_MAX  = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0]    STEP_X   = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]    ONE_X    = (WIDTH+1)'(1);

   // Upward thresholds: at or above enters the next band.
   localparam logic [WIDTH:0]    UP_TENSE    = (WIDTH+1)'(TH_TENSE);
   localparam logic [WIDTH:0]    UP_STRESSED = (WIDTH+1)'(TH_STRESSED);
   localparam logic [WIDTH:0]    UP_PANIC    = (WIDTH+1)'(TH_PANIC);

   // Downward thresholds: strictly below drops one band.
   localparam logic [WIDTH:0]    DN_TENSE    = (WIDTH+1)'(TH_TENSE - HYST);
   localparam logic [WIDTH:0]    DN_STRESSED = (WIDTH+1)'(TH_STRESSED - HYST);
   localparam logic [WIDTH:0]    DN_PANIC    = (WIDTH+1)'(TH_PANIC - HYST);

   typedef enum logic [1:0] {
      CALM     = 2'd0,
      TENSE    = 2'd1,
      STRESSED = 2'd2,
      PANIC    = 2'd3
   } mood_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q;
   logic             pend_inc_q;
   logic             pend_dec_q;
   mood_t            mood_q;

   // ---------------------------------------------------------------------------
   // Tick and effective requests. A request arriving in the tick cycle itself
   // is OR-ed in directly so it is applied on this tick rather than the next.
   // ---------------------------------------------------------------------------
   logic tick;
   logic eff_inc;
   logic eff_dec;

   assign tick    = !hold && (cnt_q == CNT_LAST);
   assign eff_inc = pend_inc_q | stress_inc;
   assign eff_dec = pend_dec_q | stress_dec;

   // ---------------------------------------------------------------------------
   // Next level computation (only committed on a tick).
   // ---------------------------------------------------------------------------
   logic [WIDTH:0] lvl_cur;
   logic [WIDTH:0] lvl_sum;
   logic [WIDTH:0] lvl_next;
   logic           lvl_changed;

   always_comb begin
      lvl_cur  = {1'b0, stress_level};
      lvl_sum  = lvl_cur + STEP_X;
      lvl_next = lvl_cur;
      if (eff_inc && !eff_dec) begin
         lvl_next = (lvl_sum > LVL_MAX) ? LVL_MAX : lvl_sum;
      end else if (eff_dec && !eff_inc) begin
         lvl_next = (lvl_cur < STEP_X) ? '0 : (lvl_cur - STEP_X);
      end
`ifdef STRESS_DECAY_EN
      else if (!eff_inc && !eff_dec && (lvl_cur != '0)) begin
         // Idle tick: relax slowly toward zero.
         lvl_next = lvl_cur - ONE_X;
      end
`endif
   end

   // The strobe must not fire on a saturated tick, so it is keyed on an
   // actual value change rather than on the request itself.
   assign lvl_changed = (lvl_next != lvl_cur);

   // ---------------------------------------------------------------------------
   // Tick counter, pending capture, level register and update strobe.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         pend_inc_q    <= 1'b0;
         pend_dec_q    <= 1'b0;
         stress_level  <= '0;
         update_strobe <= 1'b0;
      end else if (tick) begin
         cnt_q         <= '0;
         pend_inc_q    <= 1'b0;
         pend_dec_q    <= 1'b0;
         stress_level  <= lvl_next[WIDTH-1:0];
         update_strobe <= lvl_changed;
      end else begin
         if (!hold) begin
            cnt_q <= cnt_q + 1'b1;
         end
         // Requests are latched even while held; they wait for the next tick.
         pend_inc_q    <= pend_inc_q | stress_inc;
         pend_dec_q    <= pend_dec_q | stress_dec;
         update_strobe <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Mood FSM. Works from the registered level, so the band follows a level
   // change one cycle later. At most one band per cycle; the upward test wins.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         mood_q <= CALM;
      end else begin
         case (mood_q)
            CALM: begin
               if (lvl_cur >= UP_TENSE) begin
                  mood_q <= TENSE;
               end
            end
            TENSE: begin
               if (lvl_cur >= UP_STRESSED) begin
                  mood_q <= STRESSED;
               end else if (lvl_cur < DN_TENSE) begin
                  mood_q <= CALM;
               end
            end
            STRESSED: begin
               if (lvl_cur >= UP_PANIC) begin
                  mood_q <= PANIC;
               end else if (lvl_cur < DN_STRESSED) begin
                  mood_q <= TENSE;
               end
            end
            PANIC: begin
               if (lvl_cur < DN_PANIC) begin
                  mood_q <= STRESSED;
               end
            end
            default: mood_q <= CALM;
         endcase
      end
   end

   assign mood_state = mood_q;

endmodule

// File: tb/tb_stress_level_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for stress_level_ctrl.
// Clock/reset block, driver tasks that advance one cycle at a time while a
// behavioural model follows along, a table of tick-window vectors, hand-made
// sequences for saturation, hysteresis, hold, reset and decay, then a long
// randomized run checked cycle by cycle against the model.
// -----------------------------------------------------------------------------
module tb_stress_level_ctrl;

   localparam int WIDTH       = 8;
   localparam int TICK_DIV    = 16;
   localparam int STEP        = 4;
   localparam int TH_TENSE    = 64;
   localparam int TH_STRESSED = 128;
   localparam int TH_PANIC    = 224;
   localparam int HYST        = 16;
   localparam int LVL_MAX     = (1 << WIDTH) - 1;
   localparam int TH [3]      = '{TH_TENSE, TH_STRESSED, TH_PANIC};

`ifdef STRESS_DECAY_EN
   localparam bit DECAY = 1'b1;
`else
   localparam bit DECAY = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             stress_inc;
   logic             stress_dec;
   logic             hold;
   logic [WIDTH-1:0] stress_level;
   logic [1:0]       mood_state;
   logic             update_strobe;

   always #5 clk = ~clk;

   stress_level_ctrl #(
      .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STEP(STEP), .TH_TENSE(TH_TENSE),
      .TH_STRESSED(TH_STRESSED), .TH_PANIC(TH_PANIC), .HYST(HYST)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stress_inc(stress_inc),
      .stress_dec(stress_dec),
      .hold(hold),
      .stress_level(stress_level),
      .mood_state(mood_state),
      .update_strobe(update_strobe)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Plain integer bookkeeping: a phase count of unheld cycles, two request
   // flags, the level as an int and the band as an index into TH[].
   int m_level = 0;
   int m_mood  = 0;
   int m_phase = 0;
   bit m_pinc  = 1'b0;
   bit m_pdec  = 1'b0;
   bit m_strobe = 1'b0;

   task automatic model_step(input bit i, input bit d, input bit h, input bit r);
      int target;
      if (r) begin
         m_level = 0; m_mood = 0; m_phase = 0;
         m_pinc = 1'b0; m_pdec = 1'b0; m_strobe = 1'b0;
         return;
      end
      // band follows the level as it stood before this edge
      if (m_mood < 3 && m_level >= TH[m_mood]) m_mood = m_mood + 1;
      else if (m_mood > 0 && m_level < TH[m_mood-1] - HYST) m_mood = m_mood - 1;
      m_strobe = 1'b0;
      m_pinc = m_pinc | i;
      m_pdec = m_pdec | d;
      if (!h) begin
         if (m_phase == TICK_DIV - 1) begin
            target = m_level;
            if (m_pinc && !m_pdec)
               target = (m_level + STEP > LVL_MAX) ? LVL_MAX : m_level + STEP;
            else if (m_pdec && !m_pinc)
               target = (m_level < STEP) ? 0 : m_level - STEP;
            else if (!m_pinc && !m_pdec && DECAY && m_level > 0)
               target = m_level - 1;
            m_strobe = (target != m_level);
            m_level  = target;
            m_pinc = 1'b0; m_pdec = 1'b0; m_phase = 0;
         end else begin
            m_phase = m_phase + 1;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a falling edge: drive inputs, step the model, then
   // wait to the next falling edge and compare against the model.
   task automatic cyc(input bit i, input bit d, input bit h, input bit r);
      stress_inc = i; stress_dec = d; hold = h; rst = r;
      model_step(i, d, h, r);
      @(negedge clk);
      if (chk_en) begin
         chk("model_level",  int'(stress_level),  m_level);
         chk("model_mood",   int'(mood_state),    m_mood);
         chk("model_strobe", int'(update_strobe), int'(m_strobe));
      end
   endtask

   task automatic reset_dut();
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // One full tick window from counter phase 0. Returns strobes seen before
   // the tick and the mood sampled after the first cycle of the window.
   task automatic window(input int inc_at, input int dec_at,
                         output int strobe_early, output int mood_k0);
      strobe_early = 0;
      mood_k0 = -1;
      for (int k = 0; k < TICK_DIV; k++) begin
         cyc(k == inc_at, k == dec_at, 1'b0, 1'b0);
         if (k == 0) mood_k0 = int'(mood_state);
         if (k < TICK_DIV - 1 && update_strobe) strobe_early++;
      end
   endtask

   typedef struct {
      int inc_at;
      int dec_at;
      int exp_level;
      int exp_strobe;
   } vec_t;

   typedef struct {
      int len;
      int p_inc;
      int p_dec;
   } seg_t;

   // ---------------- test sequence ----------------
   initial begin
      vec_t tbl [11];
      seg_t segs [6];
      int se, mk, prev_mood, strobes, jumps, lat, bad, hold_left;
      int ent [4];
      bit found, ri, rd, rh, rr;

      // inc/dec cycle within the window (-1 = none), expected level and strobe
      tbl[0]  = '{3,  -1, 4,  1};
      tbl[1]  = '{0,  -1, 8,  1};
      tbl[2]  = '{15, -1, 12, 1};   // request in the tick cycle itself
      tbl[3]  = '{-1, 7,  8,  1};   // pending inc must have cleared
      tbl[4]  = '{2,  9,  8,  0};   // cancel
      tbl[5]  = '{9,  2,  8,  0};   // cancel
      tbl[6]  = '{15, 15, 8,  0};   // cancel in tick cycle
      tbl[7]  = '{-1, 0,  4,  1};
      tbl[8]  = '{-1, 15, 0,  1};
      tbl[9]  = '{-1, 4,  0,  0};   // saturate at 0
      tbl[10] = '{6,  -1, 4,  1};

      segs[0] = '{1800, 200, 10};
      segs[1] = '{1000, 10, 200};
      segs[2] = '{600, 40, 40};
      segs[3] = '{500, 0, 0};
      segs[4] = '{1500, 250, 10};
      segs[5] = '{800, 10, 150};

      stress_inc = 1'b0; stress_dec = 1'b0; hold = 1'b0; rst = 1'b1;
      @(negedge clk);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset_level",  int'(stress_level),  0);
      chk("reset_mood",   int'(mood_state),    0);
      chk("reset_strobe", int'(update_strobe), 0);
      chk_en = 1'b1;

      // ---- table-driven tick windows ----
      foreach (tbl[v]) begin
         window(tbl[v].inc_at, tbl[v].dec_at, se, mk);
         chk("tbl_level",        int'(stress_level),  tbl[v].exp_level);
         chk("tbl_strobe",       int'(update_strobe), tbl[v].exp_strobe);
         chk("tbl_early_strobe", se, 0);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("tbl_strobe_one_cycle", int'(update_strobe), 0);
      chk("tbl_mood_calm",        int'(mood_state),    0);

      // ---- saturation and upward mood walk ----
      reset_dut();
      prev_mood = 0; strobes = 0; jumps = 0;
      ent = '{-1, -1, -1, -1};
      for (int n = 0; n < 70; n++) begin
         for (int k = 0; k < TICK_DIV; k++) begin
            cyc(k == 5, 1'b0, 1'b0, 1'b0);
            if (update_strobe) strobes++;
            if (int'(mood_state) != prev_mood) begin
               if (int'(mood_state) == prev_mood + 1) ent[mood_state] = int'(stress_level);
               else jumps++;
               prev_mood = int'(mood_state);
            end
         end
      end
      chk("sat_level",      int'(stress_level), LVL_MAX);
      chk("sat_strobes",    strobes, 64);
      chk("sat_mood",       int'(mood_state), 3);
      chk("sat_tense_at",   ent[1], TH_TENSE);
      chk("sat_stressed_at", ent[2], TH_STRESSED);
      chk("sat_panic_at",   ent[3], TH_PANIC);
      chk("sat_band_jumps", jumps, 0);

      // ---- hysteresis on the way down from STRESSED ----
      reset_dut();
      for (int n = 0; n < 32; n++) window(0, -1, se, mk);
      chk("hyst_start_level", int'(stress_level), 128);
      for (int j = 0; j < 5; j++) begin
         window(-1, 3, se, mk);
         chk("hyst_mood_before", mk, 2);
         chk("hyst_level", int'(stress_level), 124 - 4 * j);
      end
      chk("hyst_mood_lag", int'(mood_state), 2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("hyst_mood_drop", int'(mood_state), 1);

      // ---- reset mid-window overrides hold and requests ----
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      chk("rst_level",  int'(stress_level),  0);
      chk("rst_mood",   int'(mood_state),    0);
      chk("rst_strobe", int'(update_strobe), 0);
      window(-1, -1, se, mk);
      chk("rst_pend_level",  int'(stress_level), 0);
      chk("rst_pend_strobe", int'(update_strobe) + se, 0);

      // ---- hold freezes the tick; request during hold is kept ----
      reset_dut();
      window(0, -1, se, mk);
      window(0, -1, se, mk);
      for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         cyc(k == 5, 1'b0, 1'b1, 1'b0);
         if (int'(stress_level) != 8 || update_strobe) bad++;
      end
      chk("hold_frozen", bad, 0);
      lat = 0; found = 1'b0;
      for (int w = 0; w < 40 && !found; w++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
         lat++;
         if (update_strobe) found = 1'b1;
      end
      chk("hold_release_latency", lat, 9);
      chk("hold_level", int'(stress_level), 12);

      // ---- idle ticks: decay or no change ----
      reset_dut();
      for (int n = 0; n < 3; n++) window(0, -1, se, mk);
      chk("idle_start_level", int'(stress_level), 12);
`ifdef STRESS_DECAY_EN
      window(-1, -1, se, mk);
      window(-1, -1, se, mk);
      chk("decay_to_10", int'(stress_level), 10);
      strobes = 0;
      for (int n = 0; n < 5; n++) begin
         window(-1, -1, se, mk);
         if (update_strobe) strobes++;
      end
      chk("decay_level",   int'(stress_level), 5);
      chk("decay_strobes", strobes, 5);
`else
      strobes = 0;
      for (int n = 0; n < 5; n++) begin
         window(-1, -1, se, mk);
         if (update_strobe) strobes++;
      end
      chk("idle_level",   int'(stress_level), 12);
      chk("idle_strobes", strobes, 0);
`endif

      // ---- randomized run against the model ----
      reset_dut();
      hold_left = 0;
      foreach (segs[s]) begin
         for (int c = 0; c < segs[s].len; c++) begin
            ri = ($urandom_range(0, 999) < segs[s].p_inc);
            rd = ($urandom_range(0, 999) < segs[s].p_dec);
            rr = ($urandom_range(0, 2999) == 0);
            if (hold_left > 0) begin
               rh = 1'b1;
               hold_left--;
            end else begin
               rh = 1'b0;
               if ($urandom_range(0, 99) == 0) hold_left = $urandom_range(5, 40);
            end
            cyc(ri, rd, rh, rr);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
